// File: rtl/riscv_data_ram_pkg.sv
// Package for the data RAM responder: FSM states, defaults and address window check.
package riscv_data_ram_pkg;

    `include "riscv_functions.vh"

    // Offset is taken relative to BASE_ADDR, so wrap-around below the base lands far out of range.
    function automatic logic in_window(input logic [31:0] off, input int depth_w);
        logic [32:0] lim;
        lim = 33'd4 << depth_w;
        return ({1'b0, off} < lim);
    endfunction

endpackage

// File: rtl/riscv_functions.vh
// Shared FSM encodings and parameter defaults for the data-side RAM responder.
`ifndef RISCV_FUNCTIONS_VH
`define RISCV_FUNCTIONS_VH

localparam int RISCV_WAIT_STATES_DFLT = 1;
localparam int RISCV_MEM_DEPTH_W_DFLT = 10;

typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
} ram_state_e;

`endif

// File: rtl/riscv_ram_1rw.sv
// Single-port 32-bit synchronous RAM with byte enables and registered read; contents not reset.
// Read data updates one edge after an enabled read and holds until the next read.
module riscv_ram_1rw #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/riscv_data_ram.sv
// Data-bus RAM responder: captures one transfer, waits WAIT_STATES cycles, then pulses ack for one cycle.
// Ack arrives WAIT_STATES+1 edges after req is sampled in IDLE; req is ignored until the FSM is back in IDLE.
module riscv_data_ram
    import riscv_data_ram_pkg::*;
#(
    parameter int          MEM_DEPTH_W = RISCV_MEM_DEPTH_W_DFLT,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = RISCV_WAIT_STATES_DFLT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] data_bif_addr,
    input  logic        data_bif_req,
    input  logic        data_bif_rnw,
    input  logic [3:0]  data_bif_wmask,
    input  logic [31:0] data_bif_wdata,
    output logic        data_bif_ack,
    output logic [31:0] data_bif_rdata,
    output logic        data_bif_err
);

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    ram_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic        enter_resp;
    logic [31:0] acc_addr;
    logic        acc_rnw;
    logic [3:0]  acc_wmask;
    logic [31:0] acc_wdata;
    logic [31:0] acc_off;
    logic        acc_in_range;
    logic        ram_en;
    logic [31:0] ram_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        wmask_d    = wmask_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        enter_resp = 1'b0;
        // With zero wait states the RAM is accessed on the capture edge, so use the live bus there.
        acc_addr   = addr_q;
        acc_rnw    = rnw_q;
        acc_wmask  = wmask_q;
        acc_wdata  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                acc_addr  = data_bif_addr;
                acc_rnw   = data_bif_rnw;
                acc_wmask = data_bif_wmask;
                acc_wdata = data_bif_wdata;
                if (data_bif_req) begin
                    addr_d  = data_bif_addr;
                    rnw_d   = data_bif_rnw;
                    wmask_d = data_bif_wmask;
                    wdata_d = data_bif_wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        acc_off      = acc_addr - BASE_ADDR;
        acc_in_range = in_window(acc_off, MEM_DEPTH_W);

        if (enter_resp) begin
            ack_d = 1'b1;
            err_d = ~acc_in_range;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            rnw_q   <= 1'b0;
            wmask_q <= 4'd0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // rstn gating keeps a held req from writing while the block is being reset.
    assign ram_en = enter_resp & acc_in_range & rstn;

    riscv_ram_1rw #(
        .ADDR_W (MEM_DEPTH_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (~acc_rnw),
        .addr  (acc_off[MEM_DEPTH_W+1:2]),
        .be    (acc_wmask),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign data_bif_ack   = ack_q;
    assign data_bif_err   = err_q;
    assign data_bif_rdata = (ack_q & rnw_q & ~err_q) ? ram_rdata : 32'd0;

endmodule
